// File: rtl/sam_pkg.sv
// Shared definitions for the SAM Coupe memory arbiter: grant encoding,
// FSM state type and the default memory address width.
package sam_pkg;

  localparam int unsigned SAM_AW = 25;

  // One-hot grant vector, bit order {cpu, fd, dl}
  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_DL   = 3'b001;
  localparam logic [2:0] GNT_FD   = 3'b010;
  localparam logic [2:0] GNT_CPU  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sam_state_e;

endpackage

// File: rtl/sam_arb_prio.sv
// Fixed-priority encoder (dl > fd > cpu) with CPU promotion to top
// priority once its aging counter has saturated.
module sam_arb_prio
  import sam_pkg::*;
(
  input  logic       dl_req_i,
  input  logic       fd_req_i,
  input  logic       cpu_req_i,
  input  logic       promote_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (cpu_req_i && promote_i) begin
      gnt_o = GNT_CPU;
    end else if (dl_req_i) begin
      gnt_o = GNT_DL;
    end else if (fd_req_i) begin
      gnt_o = GNT_FD;
    end else if (cpu_req_i) begin
      gnt_o = GNT_CPU;
    end
  end

endmodule

// File: rtl/sam_mem_arbiter.sv
// Single-port memory arbiter sharing the byte-wide sram port between the
// ARM download stream, the FDD2 image buffer and the Z80 CPU.
module sam_mem_arbiter
  import sam_pkg::*;
#(
  parameter int unsigned AW       = SAM_AW,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned TIMEOUT  = 31
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_ack,
  input  logic          fd_req,
  input  logic [AW-1:0] fd_addr,
  output logic          fd_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_data,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [7:0]    rd_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready,
  output logic          timeout_err
);

  localparam int unsigned AGE_W = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
  localparam int unsigned TW    = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

  sam_state_e      state_q;
  logic [2:0]      gnt_q;
  logic [AGE_W-1:0] age_q;
  logic [TW-1:0]   cnt_q;
  logic            dl_ack_q, fd_ack_q, cpu_ack_q;
  logic            mem_req_q, mem_we_q, timeout_err_q;
  logic [AW-1:0]   mem_addr_q;
  logic [7:0]      mem_din_q, rd_data_q;

  logic [2:0]      gnt;
  logic            promote;

  assign promote = (age_q == AGE_W'(MAX_WAIT));

  sam_arb_prio u_prio (
    .dl_req_i  (dl_req),
    .fd_req_i  (fd_req),
    .cpu_req_i (cpu_req),
    .promote_i (promote),
    .gnt_o     (gnt)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= GNT_NONE;
      age_q         <= '0;
      cnt_q         <= '0;
      dl_ack_q      <= 1'b0;
      fd_ack_q      <= 1'b0;
      cpu_ack_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      rd_data_q     <= '0;
    end else begin
      dl_ack_q  <= 1'b0;
      fd_ack_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      mem_req_q <= 1'b0;
      if (!cpu_req) begin
        age_q <= '0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (gnt != GNT_NONE) begin
            gnt_q     <= gnt;
            mem_req_q <= 1'b1;
            state_q   <= ST_ISSUE;
            case (gnt)
              GNT_DL: begin
                mem_addr_q <= dl_addr;
                mem_we_q   <= 1'b1;
                mem_din_q  <= dl_data;
              end
              GNT_FD: begin
                mem_addr_q <= fd_addr;
                mem_we_q   <= 1'b0;
                mem_din_q  <= '0;
              end
              default: begin
                mem_addr_q <= cpu_addr;
                mem_we_q   <= cpu_we;
                mem_din_q  <= cpu_data;
              end
            endcase
            if (gnt == GNT_CPU || !cpu_req) begin
              age_q <= '0;
            end else if (!promote) begin
              age_q <= age_q + AGE_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= TW'(TIMEOUT);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Expiry is the WAIT cycle whose decrement would reach zero, so
          // exactly TIMEOUT wait cycles are allowed; mem_ready still wins there.
          if (mem_ready) begin
            if (!mem_we_q) begin
              rd_data_q <= mem_dout;
            end
            dl_ack_q  <= gnt_q[0];
            fd_ack_q  <= gnt_q[1];
            cpu_ack_q <= gnt_q[2];
            state_q   <= ST_DONE;
          end else if (cnt_q <= TW'(1)) begin
            timeout_err_q <= 1'b1;
            rd_data_q     <= 8'hFF;
            dl_ack_q      <= gnt_q[0];
            fd_ack_q      <= gnt_q[1];
            cpu_ack_q     <= gnt_q[2];
            state_q       <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - TW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dl_ack      = dl_ack_q;
  assign fd_ack      = fd_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_wait    = cpu_req & ~cpu_ack_q;
  assign rd_data     = rd_data_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sam_mem_arbiter.sv
// Scoreboard bench for sam_mem_arbiter: directed stimulus pushes expected
// memory strobes and acks; a monitor pops and compares as they appear.
module tb_sam_mem_arbiter;
  import sam_pkg::*;

  localparam int unsigned AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          dl_req = 1'b0, fd_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] dl_addr = '0, fd_addr = '0, cpu_addr = '0;
  logic [7:0]    dl_data = '0, cpu_data = '0;
  logic          dl_ack, fd_ack, cpu_ack, cpu_wait;
  logic [7:0]    rd_data;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = '0;
  logic          mem_ready = 1'b0;
  logic          timeout_err;

  sam_mem_arbiter #(.AW(AW), .MAX_WAIT(8), .TIMEOUT(31)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .fd_req(fd_req), .fd_addr(fd_addr), .fd_ack(fd_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    din;
  } mem_exp_t;

  typedef struct {
    logic [2:0] ack;
    logic       chk_rd;
    logic [7:0] rd;
  } ack_exp_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         memreq_cyc = 0;
  int         ack_cyc[3];
  int         mem_delay = 0;        // WAIT cycles before mem_ready; <0 = never
  logic [7:0] mem_rdata = 8'h00;
  bit         stray = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic [AW-1:0] a, input logic we, input logic [7:0] d);
    mem_exp_t e;
    e.addr = a; e.we = we; e.din = d;
    mem_q.push_back(e);
  endtask

  task automatic push_ack(input logic [2:0] ack, input logic chk_rd, input logic [7:0] rd);
    ack_exp_t e;
    e.ack = ack; e.chk_rd = chk_rd; e.rd = rd;
    ack_q.push_back(e);
  endtask

  // Monitor and memory model, both at posedge+1
  initial begin
    int       cnt;
    bit       active;
    logic     prev_req;
    logic [2:0] acks;
    mem_exp_t me;
    ack_exp_t ae;
    cnt = 0; active = 0; prev_req = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      cyc++;
      if (mem_req) begin
        chk("mem_req_one_cycle", prev_req, 0);
        memreq_cyc = cyc;
        if (mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_req_unexpected: got addr 0x%0h expected no access", mem_addr);
        end else begin
          me = mem_q.pop_front();
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_we", mem_we, me.we);
          if (me.we) chk("mem_din", mem_din, me.din);
        end
      end
      prev_req = mem_req;
      acks = {cpu_ack, fd_ack, dl_ack};
      if (acks != 3'b000) begin
        for (int i = 0; i < 3; i++) if (acks[i]) ack_cyc[i] = cyc;
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got %b expected 000", acks);
        end else begin
          ae = ack_q.pop_front();
          chk("ack_sel", acks, ae.ack);
          if (ae.chk_rd) chk("rd_data", rd_data, ae.rd);
        end
      end
      mem_ready = 1'b0;
      if (reset) begin
        active = 0;
      end else begin
        if (stray) begin
          mem_ready = 1'b1; mem_dout = 8'hEE; stray = 1'b0;
        end else if (active) begin
          if (cnt == 0) begin
            mem_ready = 1'b1; mem_dout = mem_rdata; active = 0;
          end else begin
            cnt--;
          end
        end
        if (mem_req && mem_delay >= 0) begin
          active = 1; cnt = mem_delay;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys); #2;
  endtask

  // Waits for every requester in mask ({cpu,fd,dl}) to be acked, dropping its req on ack
  task automatic serve(input logic [2:0] mask, input int budget);
    logic [2:0] left;
    int n;
    left = mask; n = 0;
    while (left != 3'b000 && n < budget) begin
      step(); n++;
      if (left[0] && dl_ack)  begin dl_req = 1'b0;  left[0] = 1'b0; end
      if (left[1] && fd_ack)  begin fd_req = 1'b0;  left[1] = 1'b0; end
      if (left[2] && cpu_ack) begin cpu_req = 1'b0; left[2] = 1'b0; end
    end
    if (left != 3'b000) begin
      total++; bad++;
      $display("FAIL serve_timeout: pending %b expected 000", left);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dl_done, cpu_done;
    bit reraise;

    // Reset values
    repeat (3) step();
    chk("rst_dl_ack", dl_ack, 0);
    chk("rst_fd_ack", fd_ack, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    repeat (2) step();

    // T1: CPU read 0x12345, ready after 2 WAIT cycles
    mem_delay = 2; mem_rdata = 8'hA5;
    cpu_addr = 25'h12345; cpu_we = 1'b0; cpu_data = 8'h00; cpu_req = 1'b1;
    push_mem(25'h12345, 1'b0, 8'h00);
    push_ack(GNT_CPU, 1'b1, 8'hA5);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t1_mem_req", mem_req, (k == 1));
      chk("t1_cpu_ack", cpu_ack, (k == 5));
      chk("t1_cpu_wait", cpu_wait, (k < 5));
      if (cpu_ack) cpu_req = 1'b0;
    end
    chk("t1_rd_data", rd_data, 8'hA5);
    step();

    // T2: simultaneous dl write, fd read, cpu write
    mem_delay = 0; mem_rdata = 8'h3C;
    dl_addr = 25'h100; dl_data = 8'h11; dl_req = 1'b1;
    fd_addr = 25'h200; fd_req = 1'b1;
    cpu_addr = 25'h300; cpu_data = 8'h33; cpu_we = 1'b1; cpu_req = 1'b1;
    push_mem(25'h100, 1'b1, 8'h11);
    push_mem(25'h200, 1'b0, 8'h00);
    push_mem(25'h300, 1'b1, 8'h33);
    push_ack(GNT_DL, 1'b0, 8'h00);
    push_ack(GNT_FD, 1'b1, 8'h3C);
    push_ack(GNT_CPU, 1'b0, 8'h00);
    serve(3'b111, 40);
    chk("t2_fd_after_dl", ack_cyc[1] - ack_cyc[0], 4);
    chk("t2_cpu_after_fd", ack_cyc[2] - ack_cyc[1], 4);
    step();

    // T3: dl held for 20 accesses, cpu promoted on 9th arbitration, twice
    mem_delay = 0; mem_rdata = 8'h81;
    for (int i = 0; i < 22; i++) begin
      if (i == 8 || i == 17) begin
        push_mem(25'h50, 1'b0, 8'h00);
        push_ack(GNT_CPU, 1'b1, 8'h81);
      end else begin
        push_mem(25'h40, 1'b1, 8'h77);
        push_ack(GNT_DL, 1'b0, 8'h00);
      end
    end
    dl_addr = 25'h40; dl_data = 8'h77; dl_req = 1'b1;
    cpu_addr = 25'h50; cpu_we = 1'b0; cpu_req = 1'b1;
    dl_done = 0; cpu_done = 0; n = 0; reraise = 0;
    while ((dl_done < 20 || cpu_done < 2) && n < 400) begin
      step(); n++;
      if (reraise) begin cpu_req = 1'b1; reraise = 0; end
      if (dl_ack) begin dl_done++; if (dl_done == 20) dl_req = 1'b0; end
      if (cpu_ack) begin cpu_req = 1'b0; cpu_done++; if (cpu_done < 2) reraise = 1; end
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL t3_budget: dl=%0d cpu=%0d expected dl=20 cpu=2", dl_done, cpu_done);
    end
    dl_req = 1'b0; cpu_req = 1'b0;
    step();

    // T3b: mem_ready in the last allowed WAIT cycle beats the timeout
    mem_delay = 30; mem_rdata = 8'h5E;
    fd_addr = 25'h2AA; fd_req = 1'b1;
    push_mem(25'h2AA, 1'b0, 8'h00);
    push_ack(GNT_FD, 1'b1, 8'h5E);
    serve(3'b010, 60);
    chk("t3b_latency", ack_cyc[1] - memreq_cyc, 32);
    chk("t3b_no_timeout", timeout_err, 0);
    step();

    // T4: fd read timeout, then sticky error across a good read
    mem_delay = -1;
    fd_addr = 25'h777; fd_req = 1'b1;
    push_mem(25'h777, 1'b0, 8'h00);
    push_ack(GNT_FD, 1'b1, 8'hFF);
    serve(3'b010, 60);
    chk("t4_latency", ack_cyc[1] - memreq_cyc, 32);
    chk("t4_timeout_err", timeout_err, 1);
    step();
    mem_delay = 0; mem_rdata = 8'h19;
    fd_addr = 25'h778; fd_req = 1'b1;
    push_mem(25'h778, 1'b0, 8'h00);
    push_ack(GNT_FD, 1'b1, 8'h19);
    serve(3'b010, 20);
    chk("t4_latency_min", ack_cyc[1] - memreq_cyc, 2);
    chk("t4_timeout_sticky", timeout_err, 1);
    step();

    // T5: reset during WAIT of a CPU write
    mem_delay = -1;
    cpu_addr = 25'h55; cpu_data = 8'h99; cpu_we = 1'b1; cpu_req = 1'b1;
    push_mem(25'h55, 1'b1, 8'h99);
    step();
    chk("t5_mem_req", mem_req, 1);
    repeat (2) step();
    reset = 1'b1; cpu_req = 1'b0;
    step();
    chk("t5_cpu_ack", cpu_ack, 0);
    chk("t5_mem_req_rst", mem_req, 0);
    chk("t5_mem_we_rst", mem_we, 0);
    chk("t5_mem_addr_rst", mem_addr, 0);
    chk("t5_mem_din_rst", mem_din, 0);
    chk("t5_rd_data_rst", rd_data, 0);
    chk("t5_timeout_rst", timeout_err, 0);
    chk("t5_cpu_wait_rst", cpu_wait, 0);
    reset = 1'b0;
    repeat (4) step();
    mem_delay = 1; mem_rdata = 8'h42;
    cpu_addr = 25'h66; cpu_we = 1'b0; cpu_req = 1'b1;
    push_mem(25'h66, 1'b0, 8'h00);
    push_ack(GNT_CPU, 1'b1, 8'h42);
    serve(3'b100, 20);
    chk("t5_fresh_latency", ack_cyc[2] - memreq_cyc, 3);
    step();

    // T6: stray mem_ready in IDLE, then a normal fd read
    stray = 1'b1;
    repeat (3) step();
    mem_delay = 1; mem_rdata = 8'hC7;
    fd_addr = 25'h123; fd_req = 1'b1;
    push_mem(25'h123, 1'b0, 8'h00);
    push_ack(GNT_FD, 1'b1, 8'hC7);
    serve(3'b010, 20);
    chk("t6_latency", ack_cyc[1] - memreq_cyc, 3);
    chk("t6_no_timeout", timeout_err, 0);
    repeat (3) step();

    chk("mem_q_drained", mem_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sam_mem_arbiter.md
# sam_mem_arbiter

Single-port memory arbiter for the SAM Coupe core. It shares the one byte-wide memory port of the sram/SDRAM controller between three requesters: the ARM download stream (ROM/disk images), the FDD2 in-RAM image buffer read, and the Z80 CPU. It sits between those requesters and the sram instance. It sequences each access through a request/issue/wait/acknowledge state machine, applies fixed priority with CPU anti-starvation aging, and guards against a stalled memory with a timeout.

## Interface
Parameters:
- AW, 25, memory byte-address width
- MAX_WAIT, 8, cycles a pending CPU request may lose arbitration before it is promoted to top priority
- TIMEOUT, 31, cycles to wait for mem_ready before abandoning an access

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- dl_req  in  1  download write request; held until dl_ack
- dl_addr  in  AW  download address
- dl_data  in  8  download write data
- dl_ack  out  1  one-cycle completion pulse
- fd_req  in  1  FDD2 buffer read request; held until fd_ack
- fd_addr  in  AW  FDD2 buffer address
- fd_ack  out  1  one-cycle completion pulse; rd_data valid
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_data  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  cpu_req & ~cpu_ack; drives the CPU clock-enable gate
- rd_data  out  8  latched read data for the last completed read
- mem_req  out  1  one-cycle access strobe to memory
- mem_we  out  1  write qualifier, valid with mem_req
- mem_addr  out  AW  address, held from ISSUE until the access completes
- mem_din  out  8  write data, held with mem_addr
- mem_dout  in  8  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse from memory
- timeout_err  out  1  sticky; set on a timeout, cleared by reset

## Operation
States: IDLE, ISSUE, WAIT, DONE.

IDLE:
- Samples the requests and selects a winner.
- Default priority: dl > fd > cpu.
- If age == MAX_WAIT, cpu wins over both others.
- The winner's addr/we/data are latched into mem_* and a one-hot grant register. Next state is ISSUE.
- With no request, stays in IDLE.

ISSUE:
- Asserts mem_req for exactly one cycle, then goes to WAIT.
- The timeout counter is loaded with TIMEOUT.

WAIT:
- On mem_ready: latch mem_dout into rd_data if the access was a read, then go to DONE.
- Otherwise decrement the counter. At 0, set timeout_err, force rd_data to 8'hFF, and go to DONE.

DONE:
- Pulses the granted requester's ack, then returns to IDLE.

Write/read classes:
- dl is always a write.
- fd is always a read.
- cpu uses cpu_we.

CPU aging counter (3+ bits, saturating at MAX_WAIT):
- Increments on each IDLE arbitration where cpu_req = 1 and cpu loses.
- Clears when cpu is granted or cpu_req = 0.

Requester rule: each requester deasserts its req in the cycle it sees its ack. A req still high in the following IDLE is treated as a new access.

Requests arriving mid-access are not sampled until the next IDLE.

## Timing
- Reset values: state IDLE; all acks, mem_req, mem_we, cpu_wait, and timeout_err are 0; mem_addr, mem_din, and rd_data are 0; age is 0.
- Reset mid-access abandons the access immediately: mem_req drops and no ack is issued.
- Minimum latency, with mem_ready in the first WAIT cycle:
  - req seen in IDLE at cycle N
  - mem_req at N+1
  - mem_ready at N+2
  - ack at N+3
- Back-to-back grants: the next IDLE is at N+4. Steady-state throughput is one access per 4 cycles plus memory wait cycles.
- mem_ready arriving in ISSUE, IDLE, or DONE is ignored.
- mem_ready and counter expiry in the same cycle: mem_ready wins and no error is flagged.
- Simultaneous requests are resolved only in IDLE, by priority and age.

## Structure
- Shared package sam_pkg holds:
  - grant encoding (GNT_NONE, GNT_DL, GNT_FD, GNT_CPU)
  - state enum
  - default AW
- One natural sub-module, sam_arb_prio: a combinational priority encoder taking the three reqs and the age-promote flag and returning a one-hot grant. Everything else stays in sam_mem_arbiter.

## Test plan
- Single CPU read of 0x12345, mem_ready after 2 WAIT cycles, mem_dout = 0xA5 -> mem_req one cycle with addr 0x12345 and mem_we = 0; cpu_ack 4 cycles after mem_req; rd_data = 0xA5; cpu_wait high until cpu_ack.
- dl, fd and cpu requesting in the same cycle, mem_ready immediate -> grant order dl, fd, cpu; acks spaced 4 cycles apart.
- dl_req held continuously for 20 accesses while cpu_req is high, MAX_WAIT = 8 -> cpu granted on the 9th arbitration; age resets to 0 afterwards.
- mem_ready never arrives on an fd read -> fd_ack 32 cycles after mem_req; rd_data = 0xFF; timeout_err = 1 and stays set.
- reset asserted during WAIT of a CPU write -> no cpu_ack; all outputs at reset values the next cycle; a fresh request afterwards completes normally.
- mem_ready pulse injected while in IDLE, then a normal fd read -> stray pulse ignored; fd read returns the correct data with no early ack.
